// File: rtl/ceres_mem_arbiter.sv
// ceres_mem_arbiter: round-robin sequencer sharing one
// 128-bit single-port RAM between NUM_REQ requesters.
module ceres_mem_arbiter #(
  parameter int          NUM_REQ       = 2,
  parameter int          RAM_DEPTH     = 8192,
  parameter int          LATENCY       = 2,
  parameter logic [31:0] RAM_BASE_ADDR = 32'h8000_0000,
  parameter logic [31:0] RAM_MASK_ADDR = 32'h000F_FFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*32-1:0]  req_addr_i,
  input  logic [NUM_REQ*16-1:0]  req_wstrb_i,
  input  logic [NUM_REQ*128-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [127:0]           rsp_data_o,
  output logic                   rsp_err_o,
  output logic [$clog2(RAM_DEPTH)-1:0] ram_addr_o,
  output logic                   ram_rd_en_o,
  output logic [15:0]            ram_wr_en_o,
  output logic [127:0]           ram_wdata_o,
  input  logic [127:0]           ram_rdata_i,
  output logic                   busy_o
);

  localparam int AW = $clog2(RAM_DEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic [31:0]  addr;
    logic [15:0]  wstrb;
    logic [127:0] wdata;
  } req_t;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  last_q, owner_q;
  logic [IW-1:0]  win, cand;
  logic           win_vld;
  logic           accept;
  req_t           req_q, sel;
  logic [127:0]   rsp_data_q;
  logic           rsp_err_q;
  logic           hit, is_rd, issue;
  logic           ram_go;
  logic           miss_done, wait_done;

  // First valid requester after the last grant, wrapping.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_q) + k) % NUM_REQ);
      if (!win_vld && req_valid_i[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win == IW'(i)) begin
        sel.addr  = req_addr_i[i*32 +: 32];
        sel.wstrb = req_wstrb_i[i*16 +: 16];
        sel.wdata = req_wdata_i[i*128 +: 128];
      end
    end
  end

  assign accept = rst_ni && win_vld
               && (state_q == IDLE);

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready_o[i] = accept
                    && (win == IW'(i));
      rsp_valid_o[i] = (state_q == RESP)
                    && (owner_q == IW'(i));
    end
  end

  assign hit = (req_q.addr & ~RAM_MASK_ADDR)
            == RAM_BASE_ADDR;
  assign is_rd = (req_q.wstrb == '0);
  assign issue = (state_q == ISSUE);
  assign ram_go = issue && hit;
  assign miss_done = issue && !hit;
  assign wait_done = (state_q == WAIT)
                  && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (hit) begin
          cnt_d   = CW'(LATENCY - 1);
          state_d = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else cnt_d = cnt_q - CW'(1);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= IW'(NUM_REQ - 1);
      owner_q <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        last_q  <= win;
        owner_q <= win;
        req_q   <= sel;
      end
    end
  end

  // Response regs change only on the edge into RESP.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      unique case (1'b1)
        miss_done: begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
        wait_done: begin
          rsp_data_q <= is_rd ? ram_rdata_i : '0;
          rsp_err_q  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign ram_rd_en_o = ram_go && is_rd;
  assign ram_wr_en_o = ram_go ? req_q.wstrb : '0;
  assign ram_addr_o  = ram_go ? req_q.addr[AW+3:4]
                              : '0;
  assign ram_wdata_o = (ram_go && !is_rd)
                     ? req_q.wdata : '0;
  assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_ceres_mem_arbiter.sv
// tb_ceres_mem_arbiter: randomized scoreboard bench with
// a transaction-level model of the arbiter and the RAM.
module tb_ceres_mem_arbiter;

  localparam int L = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] MASK = 32'h000F_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [1:0]   v;
  logic [31:0]  a [2];
  logic [15:0]  s [2];
  logic [127:0] d [2];
  logic [1:0]   ready, rsp_valid;
  logic [127:0] rsp_data, ram_wdata, ram_rdata;
  logic         rsp_err, ram_rd, busy;
  logic [12:0]  ram_addr;
  logic [15:0]  ram_wr;

  ceres_mem_arbiter #(
    .NUM_REQ(2), .RAM_DEPTH(8192), .LATENCY(L),
    .RAM_BASE_ADDR(BASE), .RAM_MASK_ADDR(MASK)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(v), .req_ready_o(ready),
    .req_addr_i({a[1], a[0]}),
    .req_wstrb_i({s[1], s[0]}),
    .req_wdata_i({d[1], d[0]}),
    .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data),
    .rsp_err_o(rsp_err), .ram_addr_o(ram_addr),
    .ram_rd_en_o(ram_rd), .ram_wr_en_o(ram_wr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata),
    .busy_o(busy)
  );

  // Two extra instances for latency 1 and 16.
  logic [1:0]   lv1, lv16, rdy1, rdy16, rv1, rv16;
  logic [31:0]  la;
  logic [15:0]  ls;
  logic [127:0] ld, rdat1, rdat16, rdi1, rdi16;
  logic [127:0] wd1, wd16;
  logic         err1, err16, rd1, rd16, bz1, bz16;
  logic [12:0]  ad1, ad16;
  logic [15:0]  wr1, wr16;

  ceres_mem_arbiter #(.NUM_REQ(2), .LATENCY(1)) u_l1 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(lv1), .req_ready_o(rdy1),
    .req_addr_i({32'h0, la}),
    .req_wstrb_i({16'h0, ls}),
    .req_wdata_i({128'h0, ld}),
    .rsp_valid_o(rv1), .rsp_data_o(rdat1),
    .rsp_err_o(err1), .ram_addr_o(ad1),
    .ram_rd_en_o(rd1), .ram_wr_en_o(wr1),
    .ram_wdata_o(wd1), .ram_rdata_i(rdi1),
    .busy_o(bz1)
  );

  ceres_mem_arbiter #(.NUM_REQ(2), .LATENCY(16)) u_l16 (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(lv16), .req_ready_o(rdy16),
    .req_addr_i({32'h0, la}),
    .req_wstrb_i({16'h0, ls}),
    .req_wdata_i({128'h0, ld}),
    .rsp_valid_o(rv16), .rsp_data_o(rdat16),
    .rsp_err_o(err16), .ram_addr_o(ad16),
    .ram_rd_en_o(rd16), .ram_wr_en_o(wr16),
    .ram_wdata_o(wd16), .ram_rdata_i(rdi16),
    .busy_o(bz16)
  );

  typedef struct {
    int           cyc;
    logic [12:0]  line;
    logic         rd;
    logic [15:0]  strb;
    logic [127:0] wd;
  } ram_t;

  typedef struct {
    int           cyc;
    logic [1:0]   vld;
    logic [127:0] data;
    logic         err;
  } rsp_t;

  ram_t ram_q [$];
  rsp_t rsp_q [$];
  logic [127:0] ref_mem [int];
  logic [127:0] ram_mem [int];

  int cyc, free_cyc, busy_from, last, rd_due;
  int n_chk, n_pass;
  int gcnt [2];
  bit acc_pend [2];
  bit pv [2];
  logic [31:0]  pa [2];
  logic [15:0]  ps [2];
  logic [127:0] pd [2];
  bit rand_en, keep_busy;
  logic [127:0] rd_data;
  logic [1:0] last_ready;

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s act=%h exp=%h", nm, act, exp);
  endtask

  function automatic logic [127:0] merge(
      input logic [127:0] o, input logic [127:0] w,
      input logic [15:0] st);
    logic [127:0] r;
    r = o;
    for (int b = 0; b < 16; b++)
      if (st[b]) r[b*8 +: 8] = w[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] ref_get(input int k);
    return ref_mem.exists(k) ? ref_mem[k] : '0;
  endfunction

  function automatic logic [127:0] ram_get(input int k);
    return ram_mem.exists(k) ? ram_mem[k] : '0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic new_req(input int i);
    int r;
    r = $urandom_range(7);
    case (r)
      0: a[i] = 32'h2000_0000 + $urandom_range(255) * 16;
      1: a[i] = 32'h8010_0000 + $urandom_range(15);
      2: a[i] = 32'h800F_FFF0 + $urandom_range(15);
      default:
        a[i] = BASE + $urandom_range(15) * 16
             + $urandom_range(15);
    endcase
    s[i] = $urandom_range(1) ? 16'h0 : 16'($urandom);
    d[i] = rnd128();
    v[i] = 1'b1;
  endtask

  task automatic post(input int i, input logic [31:0] ad,
                      input logic [15:0] st);
    pa[i] = ad;
    ps[i] = st;
    pd[i] = rnd128();
    pv[i] = 1'b1;
  endtask

  // Reference: one transaction at a time, timing by rule.
  task automatic accept(input int w);
    ram_t re;
    rsp_t rs;
    bit hit, rd;
    int ln;
    hit = (a[w] & ~MASK) == BASE;
    rd  = (s[w] == 16'h0);
    ln  = int'(a[w][16:4]);
    rs.data = '0;
    if (hit) begin
      re.cyc = cyc + 1;
      re.line = a[w][16:4];
      re.rd = rd;
      re.strb = s[w];
      re.wd = d[w];
      ram_q.push_back(re);
      if (rd) rs.data = ref_get(ln);
      else ref_mem[ln] = merge(ref_get(ln), d[w], s[w]);
    end
    rs.cyc = hit ? cyc + 2 + L : cyc + 2;
    rs.vld = 2'(1 << w);
    rs.err = !hit;
    rsp_q.push_back(rs);
    busy_from = cyc + 1;
    free_cyc = hit ? cyc + 3 + L : cyc + 3;
    last = w;
    acc_pend[w] = 1'b1;
    gcnt[w]++;
  endtask

  task automatic tick();
    int w, j;
    logic [1:0] exp_r;
    logic exp_b;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (acc_pend[i]) begin
        v[i] = 1'b0;
        acc_pend[i] = 1'b0;
      end
      if (pv[i]) begin
        a[i] = pa[i];
        s[i] = ps[i];
        d[i] = pd[i];
        v[i] = 1'b1;
        pv[i] = 1'b0;
      end else if ((rand_en || keep_busy) && !v[i]
                   && (keep_busy
                       || $urandom_range(2) == 0)) begin
        new_req(i);
      end else if (rand_en && v[i]
                   && $urandom_range(15) == 0) begin
        v[i] = 1'b0;
      end
    end
    ram_rdata = (cyc == rd_due) ? rd_data : rnd128();
    #4;
    w = -1;
    if (cyc >= free_cyc) begin
      for (int k = 1; k <= 2; k++) begin
        j = (last + k) % 2;
        if (w < 0 && v[j]) w = j;
      end
    end
    exp_r = (w >= 0) ? 2'(1 << w) : 2'b00;
    exp_b = (cyc >= busy_from) && (cyc < free_cyc);
    check("req_ready", ready, exp_r);
    check("busy", busy, exp_b);
    last_ready = ready;
    if (w >= 0) accept(w);
    if (ram_rd) begin
      rd_due = cyc + L;
      rd_data = ram_get(int'(ram_addr));
    end
    if (ram_wr != 16'h0)
      ram_mem[int'(ram_addr)] =
        merge(ram_get(int'(ram_addr)), ram_wdata, ram_wr);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((v != 2'b00 || pv[0] || pv[1]
            || rsp_q.size() != 0 || ram_q.size() != 0)
           && t < 300) begin
      tick();
      t++;
    end
    check("drain_timeout", 1'(t >= 300), 1'b0);
    repeat (2) tick();
  endtask

  // Monitor: pops expectations as the DUT presents them.
  always @(negedge clk) begin
    ram_t re;
    rsp_t rs;
    #4;
    if (ram_rd || ram_wr != 16'h0) begin
      if (ram_q.size() == 0) begin
        check("ram_unexpected", {ram_rd, ram_wr}, '0);
      end else begin
        re = ram_q.pop_front();
        check("ram_cyc", cyc, re.cyc);
        check("ram_addr", ram_addr, re.line);
        check("ram_rd_en", ram_rd, re.rd);
        check("ram_wr_en", ram_wr, re.rd ? 16'h0 : re.strb);
        if (!re.rd) check("ram_wdata", ram_wdata, re.wd);
      end
    end
    if (rsp_valid != 2'b00) begin
      if (rsp_q.size() == 0) begin
        check("rsp_unexpected", rsp_valid, 2'b00);
      end else begin
        rs = rsp_q.pop_front();
        check("rsp_cyc", cyc, rs.cyc);
        check("rsp_owner", rsp_valid, rs.vld);
        check("rsp_data", rsp_data, rs.data);
        check("rsp_err", rsp_err, rs.err);
      end
    end
    while (ram_q.size() != 0 && ram_q[0].cyc < cyc) begin
      re = ram_q.pop_front();
      check("ram_missing_at", cyc, re.cyc);
    end
    while (rsp_q.size() != 0 && rsp_q[0].cyc < cyc) begin
      rs = rsp_q.pop_front();
      check("rsp_missing_at", cyc, rs.cyc);
    end
  end

  task automatic lat_run(input logic [31:0] addr,
                         input logic [15:0] strb);
    int acc [2], en [2], nen [2], r [2];
    logic [127:0] dat [2];
    logic err [2];
    logic [1:0] rv [2];
    bit hit, rd;
    int lat;
    hit = (addr & ~MASK) == BASE;
    rd = (strb == 16'h0);
    for (int i = 0; i < 2; i++) begin
      acc[i] = -1; en[i] = -1; nen[i] = 0; r[i] = -1;
      dat[i] = 'x; err[i] = 1'bx; rv[i] = 2'bxx;
    end
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 0) begin
        la = addr; ls = strb; ld = rnd128();
        lv1 = 2'b01; lv16 = 2'b01;
      end
      if (acc[0] >= 0) lv1 = 2'b00;
      if (acc[1] >= 0) lv16 = 2'b00;
      rdi1 = (en[0] >= 0) ? 128'(c - en[0]) : '1;
      rdi16 = (en[1] >= 0) ? 128'(c - en[1]) : '1;
      #4;
      if (rdy1[0] && acc[0] < 0) acc[0] = c;
      if (rdy16[0] && acc[1] < 0) acc[1] = c;
      if (rd1 || wr1 != 16'h0) begin
        nen[0]++;
        if (en[0] < 0) en[0] = c;
      end
      if (rd16 || wr16 != 16'h0) begin
        nen[1]++;
        if (en[1] < 0) en[1] = c;
      end
      if (rv1 != 2'b00 && r[0] < 0) begin
        r[0] = c; dat[0] = rdat1; err[0] = err1; rv[0] = rv1;
      end
      if (rv16 != 2'b00 && r[1] < 0) begin
        r[1] = c; dat[1] = rdat16; err[1] = err16; rv[1] = rv16;
      end
    end
    for (int i = 0; i < 2; i++) begin
      lat = (i == 0) ? 1 : 16;
      check("lat_accept_cyc", acc[i], 0);
      check("lat_rsp_cyc", r[i], hit ? 2 + lat : 2);
      check("lat_n_enables", nen[i], hit ? 1 : 0);
      if (hit) check("lat_enable_cyc", en[i], 1);
      check("lat_rsp_vld", rv[i], 2'b01);
      check("lat_data", dat[i], (hit && rd) ? 128'(lat) : '0);
      check("lat_err", err[i], !hit);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int t;
    logic [127:0] val;
    rst_n = 1'b0;
    v = 2'b11;
    for (int i = 0; i < 2; i++) begin
      a[i] = BASE; s[i] = '0; d[i] = '0;
      pv[i] = 0; acc_pend[i] = 0; gcnt[i] = 0;
    end
    lv1 = 2'b11; lv16 = 2'b11;
    la = BASE; ls = '0; ld = '0;
    rdi1 = '0; rdi16 = '0; ram_rdata = '0;
    cyc = 0; free_cyc = 0; busy_from = 0;
    last = 1; rd_due = -1;
    n_chk = 0; n_pass = 0;
    rand_en = 0; keep_busy = 0;
    for (int l = 0; l < 16; l++) begin
      val = rnd128();
      ref_mem[l] = val;
      ram_mem[l] = val;
    end
    val = rnd128();
    ref_mem[8191] = val;
    ram_mem[8191] = val;
    ref_mem[1] = {16{8'hA5}};
    ram_mem[1] = {16{8'hA5}};

    #1;
    check("rst_ready", ready, 2'b00);
    check("rst_rsp_valid", rsp_valid, 2'b00);
    check("rst_rsp_data", rsp_data, '0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_ram_en", {ram_rd, ram_wr}, '0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_l1_ready", rdy1, 2'b00);
    repeat (2) @(negedge clk);
    v = 2'b00; lv1 = 2'b00; lv16 = 2'b00;
    #1 rst_n = 1'b1;

    post(0, 32'h8000_0010, 16'h0000);
    drain();
    check("hold_a5_data", rsp_data, {16{8'hA5}});
    check("hold_a5_err", rsp_err, 1'b0);

    post(1, 32'h8000_0020, 16'h000F);
    drain();
    check("hold_wr_data", rsp_data, '0);

    post(0, 32'h2000_0000, 16'h0000);
    drain();
    check("hold_miss_err", rsp_err, 1'b1);
    check("hold_miss_data", rsp_data, '0);

    gcnt[0] = 0; gcnt[1] = 0;
    keep_busy = 1;
    repeat (60) tick();
    keep_busy = 0;
    drain();
    check("fair_both", 1'(gcnt[0] > 2 && gcnt[1] > 2), 1'b1);
    check("fair_diff",
          1'(gcnt[0] - gcnt[1] <= 1 && gcnt[1] - gcnt[0] <= 1),
          1'b1);

    rand_en = 1;
    repeat (3000) tick();
    rand_en = 0;
    drain();

    lat_run(32'h8000_0040, 16'h0000);
    lat_run(32'h8000_0050, 16'hFF00);
    lat_run(32'h2000_0000, 16'h0000);
    lat_run(32'h8001_FFF0, 16'h0000);
    for (int k = 0; k < 3; k++)
      lat_run(BASE + 32'($urandom_range(8191)) * 16, 16'h0);

    post(0, 32'h8000_0030, 16'h0000);
    t = 0;
    while (!acc_pend[0] && t < 30) begin
      tick();
      t++;
    end
    check("rst_test_accept", 1'(t < 30), 1'b1);
    tick();
    tick();
    @(negedge clk);
    #2 rst_n = 1'b0;
    v = 2'b11;
    #1;
    check("mid_rst_ready", ready, 2'b00);
    check("mid_rst_rsp_valid", rsp_valid, 2'b00);
    check("mid_rst_rsp_data", rsp_data, '0);
    check("mid_rst_ram_en", {ram_rd, ram_wr}, '0);
    check("mid_rst_busy", busy, 1'b0);
    rsp_q.delete();
    ram_q.delete();
    acc_pend[0] = 0; acc_pend[1] = 0;
    free_cyc = 0; busy_from = 0; last = 1; rd_due = -1;
    repeat (2) @(negedge clk);
    v = 2'b00;
    #1 rst_n = 1'b1;
    post(0, 32'h8000_0000, 16'h0000);
    post(1, 32'h8000_0010, 16'h0000);
    tick();
    check("post_rst_grant0", last_ready, 2'b01);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
